// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle logic/arith functions plus iterative
// unsigned multiply (shift-add) and divide/remainder (restoring).
module alu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             done,
    output logic             busy
);

    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [W2-1:0]    acc, acc_n;
    logic [WIDTH-1:0] opa, opa_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic             sel_hi, sel_hi_n;
    logic [WIDTH-1:0] y_n;
    logic             done_n;

    // Single-cycle function datapath
    logic [2:0]       f;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] alu_c;

    always_comb begin
        f  = op[2:0];
        bb = f[2] ? ~b : b;
        s  = a + bb + WIDTH'(f[2]);
        case (f[1:0])
            2'b00:   alu_c = a & bb;
            2'b01:   alu_c = a | bb;
            2'b10:   alu_c = s;
            default: alu_c = WIDTH'(s[WIDTH-1]);
        endcase
    end

    // Multiply step: acc holds {partial product high half, remaining multiplier bits}
    logic [WIDTH:0]  mul_sum;
    logic [W2-1:0]   mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Restoring divide step; a zero divisor naturally yields all-ones / dividend
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    always_comb begin
        div_shift = {rem, quo[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, opa});
        div_diff  = div_shift[WIDTH-1:0] - opa;
        rem_step  = div_ok ? div_diff : div_shift[WIDTH-1:0];
        quo_step  = {quo[WIDTH-2:0], div_ok};
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        acc_n    = acc;
        opa_n    = opa;
        rem_n    = rem;
        quo_n    = quo;
        sel_hi_n = sel_hi;
        y_n      = y;
        done_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    sel_hi_n = op[0];
                    if (!op[3]) begin
                        y_n    = alu_c;
                        done_n = 1'b1;
                    end else begin
                        case (op[2:1])
                            2'b00: begin
                                state_n = S_MUL;
                                cnt_n   = CW'(WIDTH);
                                acc_n   = {{WIDTH{1'b0}}, b};
                                opa_n   = a;
                            end
                            2'b01: begin
                                state_n = S_DIV;
                                cnt_n   = CW'(WIDTH);
                                rem_n   = '0;
                                quo_n   = a;
                                opa_n   = b;
                            end
                            default: begin
                                y_n    = '0;
                                done_n = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_MUL: begin
                acc_n = mul_next;
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    y_n     = sel_hi ? mul_next[W2-1:WIDTH] : mul_next[WIDTH-1:0];
                end
            end
            S_DIV: begin
                rem_n = rem_step;
                quo_n = quo_step;
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    y_n     = sel_hi ? rem_step : quo_step;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            rem    <= '0;
            quo    <= '0;
            sel_hi <= 1'b0;
            y      <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            opa    <= opa_n;
            rem    <= rem_n;
            quo    <= quo_n;
            sel_hi <= sel_hi_n;
            y      <= y_n;
            zero   <= (y_n == '0);
            done   <= done_n;
            busy   <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter at WIDTH=32 and WIDTH=8, sharing operand buses.
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start8;
    logic [3:0]  op_r;
    logic [31:0] a_r, b_r;
    logic [31:0] y32;
    logic [7:0]  y8;
    logic        zero32, done32, busy32;
    logic        zero8, done8, busy8;

    bit          sel;
    logic [31:0] y_s;
    logic        zero_s, done_s, busy_s;

    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    alu_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op_r),
        .a(a_r), .b(b_r), .y(y32), .zero(zero32), .done(done32), .busy(busy32)
    );

    alu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op_r),
        .a(a_r[7:0]), .b(b_r[7:0]), .y(y8), .zero(zero8), .done(done8), .busy(busy8)
    );

    assign y_s    = sel ? {24'd0, y8} : y32;
    assign zero_s = sel ? zero8 : zero32;
    assign done_s = sel ? done8 : done32;
    assign busy_s = sel ? busy8 : busy32;

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] ai,
                                          input logic [31:0] bi, input int w);
        logic [63:0] mask, x, z, r;
        mask = (64'd1 << w) - 64'd1;
        x = 64'(ai) & mask;
        z = 64'(bi) & mask;
        case (o)
            4'd0:    r = x & z;
            4'd1:    r = x | z;
            4'd2:    r = x + z;
            4'd3:    r = ((x + z) >> (w - 1)) & 64'd1;
            4'd4:    r = x & ~z;
            4'd5:    r = x | ~z;
            4'd6:    r = x - z;
            4'd7:    r = ((x - z) >> (w - 1)) & 64'd1;
            4'd8:    r = x * z;
            4'd9:    r = (x * z) >> w;
            4'd10:   r = (z == 64'd0) ? mask : x / z;
            4'd11:   r = (z == 64'd0) ? x : x % z;
            default: r = 64'd0;
        endcase
        r = r & mask;
        return r[31:0];
    endfunction

    task automatic drive_start(input bit v);
        start32 = v && !sel;
        start8  = v && sel;
    endtask

    // Drive one op, push its expectation, wait (bounded) for done.
    task automatic issue(input logic [3:0] o, input logic [31:0] ai, input logic [31:0] bi,
                         output int lat, output int busy_cyc);
        @(negedge clk);
        op_r = o; a_r = ai; b_r = bi;
        drive_start(1'b1);
        exp_q.push_back(model(o, ai, bi, sel ? 8 : 32));
        @(posedge clk);
        lat = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            drive_start(1'b0);
            lat++;
            if (busy_s) busy_cyc++;
        end while (!done_s && lat < 200);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sel = 1'b0;
        op_r = 4'b0010; a_r = 32'd5; b_r = 32'd6;
        start32 = 1'b1; start8 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            checks++;
            if (y_s !== 32'd0) begin errors++; $display("FAIL reset_y w%0d: got %h want 0", s, y_s); end
            checks++;
            if (zero_s !== 1'b1) begin errors++; $display("FAIL reset_zero w%0d: got %b want 1", s, zero_s); end
            checks++;
            if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done w%0d: got %b want 0", s, done_s); end
            checks++;
            if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy w%0d: got %b want 0", s, busy_s); end
        end
        start32 = 1'b0; start8 = 1'b0;
        reset = 1'b0;
        sel = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0]  ops[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd15};
        logic [31:0] ai, bi, e;
        int lat, bc;
        for (int p = 0; p < 2; p++) begin
            ai = (p == 0) ? 32'd32 : $urandom;
            bi = (p == 0) ? 32'd96 : $urandom;
            foreach (ops[i]) begin
                issue(ops[i], ai, bi, lat, bc);
                e = exp_q.pop_front();
                checks++;
                if (y_s !== e || zero_s !== (e == 32'd0) || lat != 1)
                begin
                    errors++;
                    $display("FAIL single op=%b w%0d: y=%h zero=%b lat=%0d want y=%h zero=%b lat=1",
                             ops[i], sel, y_s, zero_s, lat, e, (e == 32'd0));
                end
                if (!sel) last_exp = e;
                @(negedge clk);
                checks++;
                if (done_s !== 1'b0) begin errors++; $display("FAIL single_done_fall op=%b: got %b want 0", ops[i], done_s); end
            end
        end
    endtask

    task automatic test_mul();
        logic [3:0]  ops[6] = '{4'd8, 4'd9, 4'd8, 4'd9, 4'd8, 4'd9};
        logic [31:0] av[6], bv[6];
        logic [31:0] e;
        int lat, bc, w;
        w = sel ? 8 : 32;
        av = '{32'h0001_0000, 32'h0001_0000, 32'd15, 32'd15, $urandom, $urandom};
        bv = '{32'h0001_0000, 32'h0001_0000, 32'd17, 32'd17, $urandom, $urandom};
        foreach (ops[i]) begin
            issue(ops[i], av[i], bv[i], lat, bc);
            e = exp_q.pop_front();
            checks++;
            if (y_s !== e || zero_s !== (e == 32'd0) || busy_s !== 1'b0)
            begin
                errors++;
                $display("FAIL mul op=%b w%0d a=%h b=%h: y=%h zero=%b busy=%b want y=%h zero=%b busy=0",
                         ops[i], w, av[i], bv[i], y_s, zero_s, busy_s, e, (e == 32'd0));
            end
            checks++;
            if (lat != w + 1 || bc != w) begin
                errors++;
                $display("FAIL mul_latency w%0d: lat=%0d busy_cycles=%0d want %0d/%0d", w, lat, bc, w + 1, w);
            end
            if (!sel) last_exp = e;
        end
    endtask

    task automatic test_div();
        logic [3:0]  ops[6] = '{4'd10, 4'd11, 4'd10, 4'd11, 4'd10, 4'd11};
        logic [31:0] av[6], bv[6];
        logic [31:0] e;
        int lat, bc, w;
        w = sel ? 8 : 32;
        av = '{32'd100, 32'd100, 32'h1234_5678, 32'h1234_5678, $urandom, $urandom};
        bv = '{32'd7, 32'd7, 32'd0, 32'd0, $urandom_range(1, 200), $urandom_range(1, 200)};
        foreach (ops[i]) begin
            issue(ops[i], av[i], bv[i], lat, bc);
            e = exp_q.pop_front();
            checks++;
            if (y_s !== e || zero_s !== (e == 32'd0) || lat != w + 1) begin
                errors++;
                $display("FAIL div op=%b w%0d a=%h b=%h: y=%h zero=%b lat=%0d want y=%h zero=%b lat=%0d",
                         ops[i], w, av[i], bv[i], y_s, zero_s, lat, e, (e == 32'd0), w + 1);
            end
            if (!sel) last_exp = e;
        end
    endtask

    task automatic test_ignored();
        logic [31:0] e, hold;
        int lat, pulses;
        sel = 1'b0;
        hold = last_exp;
        @(negedge clk);
        op_r = 4'b1010; a_r = 32'd100; b_r = 32'd7;
        drive_start(1'b1);
        exp_q.push_back(model(4'b1010, 32'd100, 32'd7, 32));
        @(posedge clk);
        e = exp_q.pop_front();
        pulses = 0;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            drive_start(lat == 5);
            if (lat == 5) begin op_r = 4'b0010; a_r = 32'd5; b_r = 32'd6; end
            if (busy_s) begin
                checks++;
                if (y_s !== hold) begin errors++; $display("FAIL ignored_hold cyc%0d: y=%h want %h", lat, y_s, hold); end
            end
            if (done_s) begin
                pulses++;
                checks++;
                if (y_s !== e || lat != 33) begin
                    errors++;
                    $display("FAIL ignored_result: y=%h lat=%0d want %h lat=33", y_s, lat, e);
                end
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL ignored_pulses: got %0d want 1", pulses); end
        last_exp = e;
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        int lat, bc, pulses;
        sel = 1'b0;
        @(negedge clk);
        op_r = 4'b1000; a_r = 32'h0001_0000; b_r = 32'h0001_0000;
        drive_start(1'b1);
        exp_q.push_back(model(4'b1000, a_r, b_r, 32));
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            drive_start(1'b0);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_front());
        checks++;
        if (busy_s !== 1'b0 || y_s !== 32'd0 || zero_s !== 1'b1 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b y=%h zero=%b done=%b want 0/0/1/0", busy_s, y_s, zero_s, done_s);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_s) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", pulses); end
        issue(4'b0010, 32'd5, 32'd6, lat, bc);
        e = exp_q.pop_front();
        checks++;
        if (y_s !== e || lat != 1) begin errors++; $display("FAIL reset_mid_restart: y=%h lat=%0d want %h lat=1", y_s, lat, e); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  o;
        logic [31:0] e;
        sel = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (done_s !== 1'b1 || y_s !== e) begin
                    errors++;
                    $display("FAIL back_to_back #%0d: done=%b y=%h want done=1 y=%h", i, done_s, y_s, e);
                end
            end
            if (i < 8) begin
                o = 4'($urandom_range(0, 7));
                op_r = o; a_r = $urandom; b_r = $urandom;
                exp_q.push_back(model(o, a_r, b_r, 32));
                drive_start(1'b1);
            end else begin
                drive_start(1'b0);
            end
        end
        @(negedge clk);
        checks++;
        if (done_s !== 1'b0) begin errors++; $display("FAIL back_to_back_end: done=%b want 0", done_s); end
    endtask

    initial begin
        reset = 1'b1;
        start32 = 1'b0; start8 = 1'b0;
        op_r = '0; a_r = '0; b_r = '0;
        last_exp = '0;
        test_reset();
        sel = 1'b0;
        test_single();
        test_mul();
        test_div();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        sel = 1'b1;
        test_single();
        test_mul();
        test_div();
        sel = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised successor to the single-cycle processor ALU. It keeps the 3-bit single-cycle function set and adds iterative unsigned multiply and divide/remainder behind a start/done handshake. It sits in the execute stage of the multi-cycle processor variant; the controller stalls while `busy` is high.

## Interface

**Parameters**
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `CW`, default `$clog2(WIDTH+1)`: width of the iteration counter.

**Ports**
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request; sampled only when `busy` = 0.
- `op` input 4: operation. `op[3]` = 0 selects single-cycle ALU function `op[2:0]`; `op[3]` = 1 selects the extended set.
- `a` input WIDTH: operand A, latched on accepted start.
- `b` input WIDTH: operand B, latched on accepted start.
- `y` output WIDTH: registered result; held until the next completion.
- `zero` output 1: registered, equals (`y` == 0).
- `done` output 1: one-cycle pulse marking a new result on `y`.
- `busy` output 1: high while an iterative operation is in progress.

## Operation

- **Single-cycle functions, `op[3]` = 0** (`f` = `op[2:0]`):
  - `bb` = `f[2]` ? ~`b` : `b`; `s` = `a` + `bb` + `f[2]`.
  - `f[1:0]`: 00 → `a & bb`; 01 → `a | bb`; 10 → `s`; 11 → {0…, `s[WIDTH-1]`} (set-less-than).
  - All arithmetic is modulo 2^WIDTH; carry-out is discarded.
- **Extended functions, `op[3]` = 1:**
  - 1000 MUL: low WIDTH bits of `a*b`.
  - 1001 MULHU: high WIDTH bits of the unsigned `a*b`.
  - 1010 DIVU: unsigned `a/b`.
  - 1011 REMU: unsigned `a%b`.
  - 11xx: reserved; `y` = 0, completes as a single-cycle op.
- **Divide by zero:** DIVU yields all-ones; REMU yields `a`. No error flag.
- **Multiply:** shift-add over a 2·WIDTH accumulator, one bit of `b` per cycle.
- **Divide:** restoring algorithm, one quotient bit per cycle from the MSB of `a`.
- **FSM states:**
  - IDLE: accepts `start`.
  - MUL: iterates; on the last iteration → IDLE.
  - DIV: iterates; on the last iteration → IDLE.
  - IDLE + `start` + single-cycle/reserved op → stays in IDLE.
  - IDLE + `start` + op 1000/1001 → MUL; op 1010/1011 → DIV.
- **Counter:** loaded with WIDTH on entry to MUL/DIV; decrements each iteration.
- **Ignored inputs:** `start` is ignored while `busy` = 1. `a`, `b` and `op` changes after acceptance have no effect.

## Timing

- **Reset values:** `y` = 0, `zero` = 1, `done` = 0, `busy` = 0, state IDLE, counter 0. Reset overrides `start` in the same cycle.
- **Single-cycle op:** `start` sampled at edge k. `y`, `zero` and `done` = 1 are visible after edge k; `done` falls after edge k+1 unless another op completes at that edge.
- **Iterative op:**
  - `start` sampled at edge k; `busy` = 1 after edge k.
  - Iterations occur at edges k+1 … k+WIDTH.
  - After edge k+WIDTH: `y` is updated, `done` = 1, `busy` = 0.
  - Total latency is WIDTH+1 edges from acceptance.
- **Back-to-back:** a new `start` may be sampled in the cycle `done` is high, giving a continuous stream of single-cycle ops at one per cycle.
- **`y` hold:** `y` does not change while `busy` = 1; the previous result is held.
- **Reset mid-operation:** the operation is aborted and no `done` is produced. Outputs return to reset values at that edge.

## Test plan

- **Single-cycle, WIDTH=32, a=32, b=96:**
  - op 0010 → `y`=128, `done` after 1 edge.
  - op 0110 → `y`=0xFFFFFFC0.
  - op 0111 → `y`=1.
  - op 0000 → `y`=32, `zero`=0.
  - op 0001 → `y`=96.
- **Multiply, a=b=0x00010000:**
  - MUL → `y`=0, `zero`=1.
  - MULHU → `y`=1.
  - `done` exactly 33 edges after acceptance; `busy` high for 32 cycles.
- **Divide, a=100, b=7:**
  - DIVU → 14.
  - REMU → 2.
- **Divide by zero, a=0x12345678, b=0:**
  - DIVU → 0xFFFFFFFF.
  - REMU → 0x12345678.
- **Ignored inputs:** during DIVU 100/7, `start` with op 0010 and new operands at cycle 5 is ignored. Result is 14, only one `done` pulse, and `y` holds its old value until completion.
- **Reset and parameter check:**
  - `reset` at cycle 10 of MUL → `busy`=0, `y`=0, `zero`=1, no `done`.
  - Next start (op 0010, 5+6) → `y`=11.
  - Repeat all vectors with WIDTH=8: MUL 15·17 → 0xFF, MULHU → 0, latency 9 edges.
